// File: rtl/mac_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared types and default widths for the MAC accumulate stage.
//   mac_state_t : FSM state encoding {IDLE, ACCUM, DONE}
//   MAC_*_WIDTH : default parameter values for mac_accumulator
// -----------------------------------------------------------------------------
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } mac_state_t;

  localparam int MAC_IN_WIDTH  = 32;
  localparam int MAC_ACC_WIDTH = 48;
  localparam int MAC_OUT_WIDTH = 16;
  localparam int MAC_CNT_WIDTH = 16;

endpackage : mac_pkg

// File: rtl/sat_clip.sv
// -----------------------------------------------------------------------------
// sat_clip
// Combinational signed clamp from IN_WIDTH down to OUT_WIDTH.
// Ports:
//   in_i   [IN_WIDTH-1:0]  signed value to narrow
//   data_o [OUT_WIDTH-1:0] clamped signed value
//   ovf_o                  1 when in_i lies outside the OUT_WIDTH signed range
// Used by mac_accumulator only when MAC_ACCUMULATOR_SAT_EN is defined.
// -----------------------------------------------------------------------------
module sat_clip #(
  parameter int IN_WIDTH  = 48,
  parameter int OUT_WIDTH = 16
) (
  input  logic [IN_WIDTH-1:0]  in_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 ovf_o
);

  // The value fits iff every bit from the output sign bit upward matches.
  logic [IN_WIDTH-OUT_WIDTH:0] hi_bits;
  logic                        sign;

  assign hi_bits = in_i[IN_WIDTH-1:OUT_WIDTH-1];
  assign sign    = in_i[IN_WIDTH-1];
  assign ovf_o   = ~((&hi_bits) | ~(|hi_bits));

  // Clamp value: sign bit followed by its complement gives 0111.. or 1000..
  assign data_o  = ovf_o ? {sign, {(OUT_WIDTH-1){~sign}}} : in_i[OUT_WIDTH-1:0];

endmodule : sat_clip

// File: rtl/mac_accumulator.sv
// -----------------------------------------------------------------------------
// mac_accumulator
// Sums a run of num_terms signed products into a wide accumulator and presents
// the narrowed result on a held valid/ready output port.
// Optional feature macro: MAC_ACCUMULATOR_SAT_EN (saturating narrow + overflow
// flag); when undefined the result wraps and overflow is tied 0.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   prod_in         signed product (IN_WIDTH)
//   prod_valid/ready input handshake
//   num_terms       run length, sampled on the first product of a run (0 => 1)
//   out_data        narrowed result (OUT_WIDTH), stable while out_valid
//   out_valid/ready output handshake
//   busy            run in progress (state != IDLE)
//   overflow        result was saturated
// -----------------------------------------------------------------------------
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int IN_WIDTH  = MAC_IN_WIDTH,
  parameter int ACC_WIDTH = MAC_ACC_WIDTH,
  parameter int OUT_WIDTH = MAC_OUT_WIDTH,
  parameter int CNT_WIDTH = MAC_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  prod_in,
  input  logic                 prod_valid,
  output logic                 prod_ready,
  input  logic [CNT_WIDTH-1:0] num_terms,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 overflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  mac_state_t           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 overflow_q, overflow_d;

  logic [ACC_WIDTH-1:0] prod_ext;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [OUT_WIDTH-1:0] narrow_data;
  logic                 narrow_ovf;
  logic                 prod_xfer;
  logic                 out_xfer;

  // Handshake outputs decode from state only.
  assign prod_ready = (state_q != DONE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;
  assign overflow   = overflow_q;

  assign prod_xfer  = prod_valid & prod_ready;
  assign out_xfer   = out_valid & out_ready;

  assign prod_ext   = ACC_WIDTH'($signed(prod_in));

  // Candidate accumulator value if a product is taken this cycle: the first
  // product of a run replaces the old sum, later ones add to it (wrapping).
  assign acc_next   = (state_q == IDLE) ? prod_ext : (acc_q + prod_ext);

`ifdef MAC_ACCUMULATOR_SAT_EN
  sat_clip #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_sat_clip (
    .in_i   (acc_next),
    .data_o (narrow_data),
    .ovf_o  (narrow_ovf)
  );
`else
  assign narrow_data = acc_next[OUT_WIDTH-1:0];
  assign narrow_ovf  = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a variable unassigned, which would infer a latch.
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (prod_xfer) begin
          acc_d = acc_next;
          if (num_terms <= CNT_ONE) begin
            // Single-term run (0 counts as 1): result is ready immediately.
            cnt_d      = '0;
            out_data_d = narrow_data;
            overflow_d = narrow_ovf;
            state_d    = DONE;
          end else begin
            cnt_d   = num_terms - CNT_ONE;
            state_d = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (prod_xfer) begin
          acc_d = acc_next;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            out_data_d = narrow_data;
            overflow_d = narrow_ovf;
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        if (out_xfer) begin
          overflow_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      overflow_q <= overflow_d;
    end
  end

endmodule : mac_accumulator

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential accumulate stage directly downstream of the signed fixed-point multiplier in the datapath. Consumes one scaled product per cycle over a valid/ready handshake and sums a run of `num_terms` products in a wide signed accumulator. Presents the final sum, narrowed to `OUT_WIDTH`, on a held valid/ready output port. Together with the multiplier it forms the dot-product / MAC datapath.

## Interface
- `IN_WIDTH`, 32: signed product width; equals the multiplier `OUT_WIDTH`.
- `ACC_WIDTH`, 48: internal signed accumulator width; must be ≥ `IN_WIDTH`.
- `OUT_WIDTH`, 16: signed result width; must be ≤ `ACC_WIDTH`.
- `CNT_WIDTH`, 16: width of the term counter and of `num_terms`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `prod_in`  in  IN_WIDTH  signed product from the multiplier.
- `prod_valid`  in  1  `prod_in` is valid this cycle.
- `prod_ready`  out  1  block accepts `prod_in` this cycle.
- `num_terms`  in  CNT_WIDTH  run length; sampled only on the first accepted product of a run.
- `out_data`  out  OUT_WIDTH  signed result of the finished run.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer takes `out_data`.
- `busy`  out  1  a run is in progress (state ≠ IDLE).
- `overflow`  out  1  result saturated (only with `MAC_ACCUMULATOR_SAT_EN`; otherwise tied 0).

## Operation
- Transfer on `prod_valid && prod_ready`. Output transfer on `out_valid && out_ready`.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `prod_ready`=1.
  - On transfer: `acc` ← sign-extended `prod_in`; `cnt` ← `num_terms`−1.
  - `num_terms` of 0 is treated as 1.
  - If the effective `num_terms` is 1, go to DONE; otherwise go to ACCUM.
- ACCUM:
  - `prod_ready`=1.
  - On transfer: `acc` ← `acc` + sext(`prod_in`); `cnt` ← `cnt`−1.
  - When the transfer happens with `cnt`==1, go to DONE.
  - Without a transfer, hold state, `acc` and `cnt`. Gaps in `prod_valid` are allowed.
- DONE:
  - `prod_ready`=0, `out_valid`=1.
  - `out_data` and `overflow` are held stable until the output transfer.
  - On output transfer, go to IDLE. No product is accepted in that cycle.
- Arithmetic:
  - Two's complement throughout.
  - `acc` wraps at `ACC_WIDTH`; no internal saturation.
  - No rescaling: the multiplier has already applied `OUT_SCALE`.
- Narrowing `acc` to `out_data` is governed by Configuration.
- `num_terms` changing mid-run has no effect on the current run.

## Timing
- Reset values: state IDLE, `acc`=0, `cnt`=0, `out_data`=0, `out_valid`=0, `overflow`=0, `busy`=0. `prod_ready`=1 from the first cycle after reset.
- `prod_ready` and `out_valid` are decoded from state only, never from `prod_valid` or `out_ready`.
- Latency: `out_valid` rises on the first edge after the last product transfer.
- Throughput:
  - One product per cycle while accumulating.
  - Minimum one idle cycle between runs (the DONE handshake cycle).
  - An N-term run with back-to-back products and `out_ready`=1 occupies N+1 cycles.
- `rst` asserted in any state, including mid-run or with `out_valid` high, aborts the run. The pending result is discarded; all registers return to reset values on that edge.
- `rst` takes priority over both handshakes in the same cycle.

## Configuration
- Macro: `MAC_ACCUMULATOR_SAT_EN`.
- Defined:
  - If `acc` exceeds the signed `OUT_WIDTH` range, `out_data` clamps to 2^(OUT_WIDTH−1)−1 or −2^(OUT_WIDTH−1).
  - `overflow`=1 with that result; it clears at the output transfer or on reset.
- Undefined:
  - `out_data` = `acc[OUT_WIDTH-1:0]` (wrap).
  - `overflow` tied 0. No saturation logic is instantiated.

## Structure
- Package `mac_pkg` holds:
  - the state enum typedef `mac_state_t` {IDLE, ACCUM, DONE};
  - default width localparams: IN 32, ACC 48, OUT 16, CNT 16.
- One sub-module `sat_clip` (parameters `IN_WIDTH`, `OUT_WIDTH`; combinational clamp plus overflow flag). It is instantiated only under `MAC_ACCUMULATOR_SAT_EN`.
- FSM, counter and accumulator live in `mac_accumulator`.

## Test plan
- Reset then `num_terms`=4, back-to-back products 3, −1, 10, 2 with `out_ready`=1 → `out_valid` is high 1 cycle after the 4th transfer with `out_data`=14, then IDLE the following cycle.
- `num_terms`=0 with a single product −7 → treated as 1; `out_data`=−7 on the next cycle.
- `num_terms`=3 with `prod_valid` gaps of 2 cycles between products 5, 5, 5, and `out_ready` held low 3 cycles → `out_data`=15 held stable, `prod_ready`=0 throughout DONE.
- Assert `rst` after the 2nd of 4 terms (values 100, 200) → all outputs 0 next cycle. A following 1-term run of 9 yields 9, with no residue.
- `num_terms`=2 with products 30000 and 10000 (OUT_WIDTH 16): with the macro, `out_data`=32767 and `overflow`=1; without it, `out_data`=−25536 and `overflow`=0.
- `num_terms`=2 with products −32768 and −1: with the macro, `out_data`=−32768 and `overflow`=1; change `num_terms` to 5 mid-run → the run still ends after 2 terms.
